// File: rtl/lsb_extract.sv
// LSB steganography recovery stage: packs bit 0 of each accepted pixel byte
// MSB-first into message bytes and streams them out over valid/ready.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   start           one-cycle pulse, begins a run (honoured only when idle)
//   pix_valid/ready pixel-byte handshake; pix_byte carries the stego byte
//   msg_valid/ready message-byte handshake; msg_byte, msg_last qualify it
//   busy            high whenever a run is in progress (not idle)
//   done            one-cycle pulse after the final byte is taken
//   byte_count      bytes emitted in the current/last run
module lsb_extract #(
    parameter int MAX_BYTES = 130,
    parameter int CW        = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [7:0]    pix_byte,
    output logic          msg_valid,
    input  logic          msg_ready,
    output logic [7:0]    msg_byte,
    output logic          msg_last,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] byte_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    msg_byte_q, msg_byte_d;
    logic          msg_last_q, msg_last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pix_ready_q;
    logic          msg_valid_q;
    logic          busy_q;
    logic          done_q;

    logic [7:0]    shift_nx;
    logic          cnt_at_max;
    logic          unused_px;

    // Only the LSB of each channel byte carries payload.
    assign unused_px  = ^pix_byte[7:1];
    assign shift_nx   = {shift_q[6:0], pix_byte[0]};
    assign cnt_at_max = (cnt_q == CW'(MAX_BYTES - 1));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        msg_byte_d = msg_byte_q;
        msg_last_d = msg_last_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    state_d   = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (pix_valid && pix_ready_q) begin
                    shift_d   = shift_nx;
                    // 3-bit counter wraps to 0 on the 8th bit.
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        msg_byte_d = shift_nx;
                        // Decided at load time so msg_last is a flop,
                        // stable for the whole emit phase.
                        msg_last_d = (shift_nx == 8'h00) | cnt_at_max;
                        state_d    = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (msg_ready) begin
                    cnt_d      = cnt_q + CW'(1);
                    msg_last_d = 1'b0;
                    state_d    = msg_last_q ? S_DONE : S_COLLECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so that no
    // input reaches an output combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            msg_byte_q  <= '0;
            msg_last_q  <= 1'b0;
            cnt_q       <= '0;
            pix_ready_q <= 1'b0;
            msg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            msg_byte_q  <= msg_byte_d;
            msg_last_q  <= msg_last_d;
            cnt_q       <= cnt_d;
            pix_ready_q <= (state_d == S_COLLECT);
            msg_valid_q <= (state_d == S_EMIT);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign pix_ready  = pix_ready_q;
    assign msg_valid  = msg_valid_q;
    assign msg_byte   = msg_byte_q;
    assign msg_last   = msg_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_lsb_extract.sv
// Self-checking bench for lsb_extract: cycle-accurate vector table for
// full runs, plus directed sequences for reset abort and truncation.
module tb_lsb_extract;

    localparam int MAXB = 130;

    logic       clk;
    logic       rst_n;
    logic       start, pv, mr;
    logic [7:0] pb;
    logic       pr, mv, ml, bsy, dn;
    logic [7:0] mb;
    logic [7:0] cnt;

    logic       t_start, t_pv, t_mr;
    logic [7:0] t_pb;
    logic       t_pr, t_mv, t_ml, t_bsy, t_dn;
    logic [7:0] t_mb;
    logic [1:0] t_cnt;

    int n_chk;
    int n_fail;

    lsb_extract #(.MAX_BYTES(MAXB)) u_dut (
        .clk(clk), .reset(rst_n), .start(start),
        .pix_valid(pv), .pix_ready(pr), .pix_byte(pb),
        .msg_valid(mv), .msg_ready(mr), .msg_byte(mb),
        .msg_last(ml), .busy(bsy), .done(dn), .byte_count(cnt)
    );

    lsb_extract #(.MAX_BYTES(2)) u_t (
        .clk(clk), .reset(rst_n), .start(t_start),
        .pix_valid(t_pv), .pix_ready(t_pr), .pix_byte(t_pb),
        .msg_valid(t_mv), .msg_ready(t_mr), .msg_byte(t_mb),
        .msg_last(t_ml), .busy(t_bsy), .done(t_dn), .byte_count(t_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit       st;
        bit       pv;
        bit [7:0] pb;
        bit       mr;
        bit       pr;
        bit       mv;
        bit [7:0] mb;
        bit       ml;
        bit       bsy;
        bit       dn;
        int       cnt;
    } vec_t;

    vec_t     tv[$];
    bit [7:0] run_q[$];
    bit [7:0] demo[8];
    bit [7:0] exp_mb;
    int       exp_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input bit st, input bit v, input bit [7:0] b,
                       input bit r, input bit e_pr, input bit e_mv,
                       input bit [7:0] e_mb, input bit e_ml,
                       input bit e_bsy, input bit e_dn, input int e_cnt);
        vec_t x;
        x.st = st; x.pv = v; x.pb = b; x.mr = r;
        x.pr = e_pr; x.mv = e_mv; x.mb = e_mb; x.ml = e_ml;
        x.bsy = e_bsy; x.dn = e_dn; x.cnt = e_cnt;
        tv.push_back(x);
    endtask

    // Expected cycle-by-cycle behaviour of one run over run_q.
    task automatic gen_run(input int stall_k, input int stall_n,
                           input int start_k, input bit gaps);
        bit [7:0] b;
        bit       last;
        int       n;
        n = 0;
        add(1, 0, 8'h00, 1, 0, 0, exp_mb, 0, 0, 0, exp_cnt);
        for (int k = 0; k < run_q.size(); k++) begin
            b    = run_q[k];
            last = (b == 8'h00) || (k == MAXB - 1);
            for (int j = 0; j < 8; j++) begin
                if (gaps && j == 2)
                    add(0, 0, 8'hFF, 1, 1, 0, exp_mb, 0, 1, 0, k);
                add(start_k == k && j == 3, 1, {demo[j][7:1], b[7-j]}, 1,
                    1, 0, exp_mb, 0, 1, 0, k);
            end
            if (k == stall_k)
                for (int s = 0; s < stall_n; s++)
                    add(0, 1, (s % 2 == 0) ? 8'hFF : 8'hFE, 0,
                        0, 1, b, last, 1, 0, k);
            add(0, 1, 8'h01, 1, 0, 1, b, last, 1, 0, k);
            exp_mb = b;
            n      = k + 1;
            if (last) break;
        end
        exp_cnt = n;
        add(0, 0, 8'h00, 0, 0, 0, exp_mb, 0, 1, 1, exp_cnt);
        add(0, 0, 8'h00, 0, 0, 0, exp_mb, 0, 0, 0, exp_cnt);
    endtask

    task automatic drive_byte(input bit [7:0] b, input int nbits);
        for (int j = 0; j < nbits; j++) begin
            @(posedge clk); #1;
            start = 0;
            pv    = 1;
            pb    = {7'h2A, b[7-j]};
        end
    endtask

    initial begin
        bit [23:0] stream;
        bit [7:0]  got_b[4];
        bit        got_l[4];
        int        idx, nmsg, ndone;
        string     tag;

        n_chk = 0; n_fail = 0;
        rst_n = 0; start = 0; pv = 0; pb = 0; mr = 0;
        t_start = 0; t_pv = 0; t_pb = 0; t_mr = 0;
        demo[0] = 8'hA4; demo[1] = 8'h3F; demo[2] = 8'h10; demo[3] = 8'hFE;
        demo[4] = 8'h22; demo[5] = 8'h08; demo[6] = 8'h6C; demo[7] = 8'h91;
        exp_mb = 8'h00; exp_cnt = 0;

        // Run 1: basic 'A' then a bare terminator.
        run_q = {8'h41, 8'h00};
        gen_run(-1, 0, -1, 0);
        // Run 2: "Hi\0" with pixel gaps, a stray start, 5-cycle stall on 'i'.
        run_q = {8'h48, 8'h69, 8'h00};
        gen_run(1, 5, 0, 1);

        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk); #1;
            start = tv[i].st; pv = tv[i].pv; pb = tv[i].pb; mr = tv[i].mr;
            @(negedge clk);
            tag = $sformatf("v%0d", i);
            chk({tag, " pix_ready"}, int'(pr), int'(tv[i].pr));
            chk({tag, " msg_valid"}, int'(mv), int'(tv[i].mv));
            chk({tag, " msg_byte"}, int'(mb), int'(tv[i].mb));
            chk({tag, " msg_last"}, int'(ml), int'(tv[i].ml));
            chk({tag, " busy"}, int'(bsy), int'(tv[i].bsy));
            chk({tag, " done"}, int'(dn), int'(tv[i].dn));
            chk({tag, " byte_count"}, int'(cnt), tv[i].cnt);
        end

        // Reset in the middle of a byte discards the partial bits.
        @(posedge clk); #1;
        start = 1; mr = 1; pv = 0;
        drive_byte(8'hC3, 8);
        @(posedge clk); #1 pv = 0;
        @(negedge clk);
        chk("rst pre msg_byte", int'(mb), 8'hC3);
        chk("rst pre msg_valid", int'(mv), 1);
        drive_byte(8'hFF, 5);
        @(posedge clk); #1 pv = 0;
        #2 rst_n = 0;
        #1;
        chk("rst pix_ready", int'(pr), 0);
        chk("rst msg_valid", int'(mv), 0);
        chk("rst msg_byte", int'(mb), 0);
        chk("rst msg_last", int'(ml), 0);
        chk("rst busy", int'(bsy), 0);
        chk("rst done", int'(dn), 0);
        chk("rst byte_count", int'(cnt), 0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1 start = 1;
        drive_byte(8'h5A, 8);
        @(posedge clk); #1 pv = 0;
        @(negedge clk);
        chk("fresh msg_valid", int'(mv), 1);
        chk("fresh msg_byte", int'(mb), 8'h5A);
        chk("fresh msg_last", int'(ml), 0);
        chk("fresh byte_count", int'(cnt), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fresh count after", int'(cnt), 1);
        chk("fresh pix_ready", int'(pr), 1);

        // Truncation at MAX_BYTES=2 with a three-byte pixel stream.
        stream = 24'h414243;
        idx = 0; nmsg = 0; ndone = 0;
        @(posedge clk); #1 t_start = 1; t_mr = 1;
        @(posedge clk); #1 t_start = 0;
        for (int c = 0; c < 80; c++) begin
            t_pv = (idx < 24);
            t_pb = (idx < 24) ? {7'h55, stream[23-idx]} : 8'h00;
            @(negedge clk);
            if (t_pv && t_pr) idx++;
            if (t_mv && t_mr && nmsg < 4) begin
                got_b[nmsg] = t_mb;
                got_l[nmsg] = t_ml;
                nmsg++;
            end
            if (t_dn) ndone++;
            @(posedge clk); #1;
        end
        t_pv = 0;
        chk("trunc pixels accepted", idx, 16);
        chk("trunc bytes emitted", nmsg, 2);
        chk("trunc byte0", int'(got_b[0]), 8'h41);
        chk("trunc last0", int'(got_l[0]), 0);
        chk("trunc byte1", int'(got_b[1]), 8'h42);
        chk("trunc last1", int'(got_l[1]), 1);
        chk("trunc done pulses", ndone, 1);
        chk("trunc byte_count", int'(t_cnt), 2);
        chk("trunc busy", int'(t_bsy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
